// File: rtl/mul_arb_pkg.sv
// Shared widths and pipeline-stage records for the multiplier arbiter.
package mul_arb_pkg;

   localparam int OPW    = 8;
   localparam int PRODW  = 16;
   // Wide enough for the largest supported requester count (8)
   localparam int IDMAXW = 3;

   typedef struct packed {
      logic              valid;
      logic [IDMAXW-1:0] id;
      logic [OPW-1:0]    a;
      logic [OPW-1:0]    b;
   } s1_t;

   typedef struct packed {
      logic              valid;
      logic [IDMAXW-1:0] id;
      logic [PRODW-1:0]  prod;
   } s2_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx
);

   logic           found;
   logic [IDW-1:0] j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = IDW'((32'(ptr) + k) % NREQ);
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
      if (found) grant[idx] = en;
   end

endmodule

// File: rtl/slm_1.sv
// Combinational unsigned 8x8 array multiplier (shift-and-add rows).
module slm_1 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   always_comb begin
      p = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p + ({8'b0, a} << i);
      end
   end

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one slm_1 multiplier across NREQ requesters.
// Optional per-requester accept counters with MUL_ARB_PERF_CNT_EN.
module mul_rr_arbiter
   import mul_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*8-1:0]   req_a,
   input  logic [NREQ*8-1:0]   req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [15:0]         rsp_prod,
   output logic                busy
`ifdef MUL_ARB_PERF_CNT_EN
   ,
   output logic [NREQ*16-1:0]  perf_cnt,
   input  logic                perf_clr
`endif
);

   s1_t             s1;
   s2_t             s2;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  widx;
   logic [NREQ-1:0] grant;
   logic            s1_ready;
   logic            s2_ready;
   logic            accept;
   logic [OPW-1:0]  sel_a;
   logic [OPW-1:0]  sel_b;
   logic [PRODW-1:0] prod;

   assign s2_ready = !s2.valid || rsp_ready;
   assign s1_ready = !s1.valid || s2_ready;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (s1_ready),
      .grant (grant),
      .idx   (widx)
   );

   // Grant is only ever raised on a valid request, so any grant bit is an accept
   assign req_ready = grant;
   assign accept    = |grant;
   assign sel_a     = req_a[widx*OPW +: OPW];
   assign sel_b     = req_b[widx*OPW +: OPW];

   slm_1 u_mul (
      .a (s1.a),
      .b (s1.b),
      .p (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= '0;
         s2  <= '0;
         ptr <= '0;
      end else begin
         if (accept) begin
            s1  <= '{valid: 1'b1, id: IDMAXW'(widx), a: sel_a, b: sel_b};
            ptr <= (widx == IDW'(NREQ-1)) ? '0 : widx + 1'b1;
         end else if (s2_ready) begin
            s1.valid <= 1'b0;
         end

         if (s1.valid && s2_ready) begin
            s2 <= '{valid: 1'b1, id: s1.id, prod: prod};
         end else if (rsp_ready) begin
            s2.valid <= 1'b0;
         end
      end
   end

   assign rsp_valid = s2.valid;
   assign rsp_id    = IDW'(s2.id);
   assign rsp_prod  = s2.prod;
   assign busy      = s1.valid || s2.valid;

`ifdef MUL_ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (perf_clr) begin
               perf_cnt[i*16 +: 16] <= '0;
            end else if (req_valid[i] && grant[i] && (perf_cnt[i*16 +: 16] != 16'hFFFF)) begin
               perf_cnt[i*16 +: 16] <= perf_cnt[i*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed self-checking bench for mul_rr_arbiter (NREQ=4).
module tb_mul_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_prod;
   logic        busy;
`ifdef MUL_ARB_PERF_CNT_EN
   logic [63:0] perf_cnt;
   logic        perf_clr = 1'b0;
`endif

   int unsigned passed = 0;
   int unsigned fails  = 0;
   int unsigned total  = 0;

   always #5 clk = ~clk;

   mul_rr_arbiter #(.NREQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_prod  (rsp_prod),
      .busy      (busy)
`ifdef MUL_ARB_PERF_CNT_EN
      ,
      .perf_cnt  (perf_cnt),
      .perf_clr  (perf_clr)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Single isolated transaction, rsp_ready assumed high
   task automatic run_one(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
      req_a[idx*8 +: 8] = a;
      req_b[idx*8 +: 8] = b;
      req_valid = 4'(1 << idx);
      #1;
      chk("one_ready", req_ready, 1 << idx);
      tick();
      req_valid = '0;
      chk("one_lat1_valid", rsp_valid, 0);
      chk("one_lat1_busy", busy, 1);
      tick();
      chk("one_valid", rsp_valid, 1);
      chk("one_id", rsp_id, idx);
      chk("one_prod", rsp_prod, exp);
      tick();
      chk("one_drain_valid", rsp_valid, 0);
      chk("one_drain_busy", busy, 0);
   endtask

   logic [15:0] exp_p [4];
   logic [4:0]  exp_rdy;
   logic        took;
   int          n;

   initial begin
      exp_p = '{16'd21, 16'd152, 16'd315, 16'd510};
      #2;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_prod", rsp_prod, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;

      // 3*5 on requester 0
      run_one(0, 8'd3, 8'd5, 16'd15);

      // All four requesters held valid from ptr=0
      do_reset();
      req_a = {8'd51, 8'd35, 8'd19, 8'd3};
      req_b = {8'd10, 8'd9, 8'd8, 8'd7};
      for (int k = 0; k < 6; k++) begin
         req_valid = '1;
         #1;
         chk("rr_grant", req_ready, 1 << (k % 4));
         tick();
         if (k >= 1) begin
            chk("rr_valid", rsp_valid, 1);
            chk("rr_id", rsp_id, (k - 1) % 4);
            chk("rr_prod", rsp_prod, exp_p[(k - 1) % 4]);
         end
      end
      req_valid = '0;
      tick();
      chk("rr_last_id", rsp_id, 1);
      chk("rr_last_prod", rsp_prod, 16'd152);
      tick();
      chk("rr_idle", rsp_valid, 0);

      // Backpressure: stream requester 1 with rsp_ready low
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      exp_rdy = 5'b00011;
      n = 0;
      for (int c = 0; c < 5; c++) begin
         req_a[15:8] = 8'(10 + n);
         req_b[15:8] = 8'd2;
         #1;
         chk("bp_ready", req_ready, {2'b00, exp_rdy[c], 1'b0});
         took = req_ready[1];
         tick();
         if (took) n++;
         if (c >= 1) begin
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_id", rsp_id, 1);
            chk("bp_hold_prod", rsp_prod, 16'd20);
         end
      end
      chk("bp_accepts", n, 2);
      rsp_ready = 1'b1;
      req_a[15:8] = 8'(10 + n);
      #1;
      chk("bp_refill_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      chk("bp_rsp1_prod", rsp_prod, 16'd22);
      chk("bp_rsp1_valid", rsp_valid, 1);
      tick();
      chk("bp_rsp2_prod", rsp_prod, 16'd24);
      chk("bp_rsp2_valid", rsp_valid, 1);
      tick();
      chk("bp_done_valid", rsp_valid, 0);
      chk("bp_done_busy", busy, 0);

      // Pointer moves past the last winner
      req_a[23:16] = 8'd4; req_b[23:16] = 8'd4;
      req_a[31:24] = 8'd5; req_b[31:24] = 8'd5;
      req_a[15:8]  = 8'd6; req_b[15:8]  = 8'd6;
      req_valid = 4'b0100;
      #1;
      chk("ptr_g2", req_ready, 4'b0100);
      tick();
      req_valid = 4'b1010;
      #1;
      chk("ptr_g3", req_ready, 4'b1000);
      tick();
      chk("ptr_rsp2_id", rsp_id, 2);
      chk("ptr_rsp2_prod", rsp_prod, 16'd16);
      req_valid = 4'b0010;
      #1;
      chk("ptr_g1", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      chk("ptr_rsp3_id", rsp_id, 3);
      chk("ptr_rsp3_prod", rsp_prod, 16'd25);
      tick();
      chk("ptr_rsp1_id", rsp_id, 1);
      chk("ptr_rsp1_prod", rsp_prod, 16'd36);
      tick();
      chk("ptr_idle", rsp_valid, 0);

      // Arithmetic corners
      run_one(3, 8'hFF, 8'hFF, 16'hFE01);
      run_one(1, 8'h00, 8'hA5, 16'h0000);

      // Reset with two results in flight
      rsp_ready = 1'b0;
      req_a[7:0] = 8'd7;
      req_b[7:0] = 8'd7;
      req_valid = 4'b0001;
      tick();
      tick();
      req_valid = '0;
      chk("inflight_busy", busy, 1);
      chk("inflight_valid", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", rsp_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_prod", rsp_prod, 0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("postrst_valid", rsp_valid, 0);
      end

`ifdef MUL_ARB_PERF_CNT_EN
      do_reset();
      chk("perf_rst", perf_cnt[31:0], 0);
      chk("perf_rst_hi", perf_cnt[63:32], 0);
      req_valid = 4'b0100;
      tick();
      tick();
      tick();
      req_valid = '0;
      chk("perf_req2", perf_cnt[47:32], 3);
      chk("perf_others", {perf_cnt[63:48], perf_cnt[31:16]}, 0);
      req_valid = 4'b0100;
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      req_valid = '0;
      chk("perf_clr_wins", perf_cnt[47:32], 0);
      tick();
      tick();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
